// File: rtl/scale_copier.sv
// scale_copier
//   Copies a source image from a ROM into a framebuffer RAM, scaling it on
//   the way. The scale mode is latched once after reset:
//     00 -> 2x zoom (nearest neighbour), 01 -> 1/2 shrink (2x2 average),
//     10/11 -> 1x copy.
//   Each output pixel is produced by RD/CAP tap cycles followed by one WR cycle.
//   The output pixel is written in raster order.
//
// Ports
//   clk_i         pixel clock, all state changes on its rising edge
//   reset_i       asynchronous active-high reset (restarts the copy)
//   seletor_i     scale mode select, sampled only in LOAD
//   rom_addr_o    registered source ROM address
//   rom_data_i    source ROM pixel, valid one clock after rom_addr_o
//   ram_wraddr_o  registered framebuffer write address
//   ram_data_o    registered framebuffer write data
//   ram_wren_o    framebuffer write strobe, one cycle per output pixel
//   done_o        high once the whole scaled image has been written
module scale_copier #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [1:0]  seletor_i,
  output logic [18:0] rom_addr_o,
  input  logic [7:0]  rom_data_i,
  output logic [18:0] ram_wraddr_o,
  output logic [7:0]  ram_data_o,
  output logic        ram_wren_o,
  output logic        done_o
);

  typedef enum logic [2:0] {S_LOAD, S_RD, S_CAP, S_WR, S_DONE} state_e;
  typedef enum logic [1:0] {MODE_ZOOM = 2'b00, MODE_HALF = 2'b01, MODE_COPY = 2'b10} mode_e;

  state_e      state_q, state_d;
  mode_e       mode_q, mode_d;
  logic [15:0] ox_q, ox_d, oy_q, oy_d;
  logic [15:0] outW, outH;
  logic [1:0]  tap_q, tap_d;
  logic [9:0]  acc_q, acc_d, sum;
  logic [31:0] sx, sy;
  logic [18:0] rom_addr_q, rom_addr_d;
  logic [18:0] ram_wraddr_q, ram_wraddr_d;
  logic [7:0]  ram_data_q, ram_data_d;
  logic        ram_wren_q, done_q;

  // Output geometry of the latched mode; only consulted in CAP and WR,
  // where the mode register is already valid.
  always_comb begin
    outW = 16'(IMG_W);
    outH = 16'(IMG_H);
    case (mode_q)
      MODE_ZOOM: begin
        outW = 16'(2 * IMG_W);
        outH = 16'(2 * IMG_H);
      end
      MODE_HALF: begin
        outW = 16'(IMG_W / 2);
        outH = 16'(IMG_H / 2);
      end
      default: begin
        outW = 16'(IMG_W);
        outH = 16'(IMG_H);
      end
    endcase
  end

  // Next-state logic: LOAD -> RD -> CAP -> (RD for more taps | WR) -> RD | DONE.
  // The 10-bit accumulator holds up to four 8-bit taps without overflow.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    tap_d      = tap_q;
    acc_d      = acc_q;
    ram_data_d = ram_data_q;
    sum        = acc_q + {2'b00, rom_data_i};
    case (state_q)
      S_LOAD: begin
        if (seletor_i[1]) begin
          mode_d = MODE_COPY;
        end else if (seletor_i[0]) begin
          mode_d = MODE_HALF;
        end else begin
          mode_d = MODE_ZOOM;
        end
        ox_d    = '0;
        oy_d    = '0;
        tap_d   = '0;
        acc_d   = '0;
        state_d = S_RD;
      end
      S_RD: begin
        state_d = S_CAP;
      end
      S_CAP: begin
        acc_d = sum;
        if (mode_q == MODE_HALF && tap_q != 2'd3) begin
          tap_d   = 2'(tap_q + 2'd1);
          state_d = S_RD;
        end else begin
          // Shrink mode writes the truncated average; the others pass the tap through.
          ram_data_d = (mode_q == MODE_HALF) ? sum[9:2] : rom_data_i;
          state_d    = S_WR;
        end
      end
      S_WR: begin
        acc_d = '0;
        tap_d = '0;
        if (ox_q == outW - 16'd1) begin
          if (oy_q == outH - 16'd1) begin
            state_d = S_DONE;
          end else begin
            ox_d    = '0;
            oy_d    = oy_q + 16'd1;
            state_d = S_RD;
          end
        end else begin
          ox_d    = ox_q + 16'd1;
          state_d = S_RD;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // Address generation. The ROM address is computed from the next-state
  // counters so it is already registered while the FSM sits in RD; it holds
  // its value in every other state.
  always_comb begin
    sx = '0;
    sy = '0;
    case (mode_d)
      MODE_ZOOM: begin
        sx = 32'(ox_d >> 1);
        sy = 32'(oy_d >> 1);
      end
      MODE_HALF: begin
        sx = {15'b0, ox_d, 1'b0} + 32'(tap_d[0]);
        sy = {15'b0, oy_d, 1'b0} + 32'(tap_d[1]);
      end
      default: begin
        sx = 32'(ox_d);
        sy = 32'(oy_d);
      end
    endcase
    rom_addr_d   = (state_d == S_RD) ? 19'(sy * 32'(IMG_W) + sx) : rom_addr_q;
    ram_wraddr_d = (state_d == S_WR) ? 19'(32'(oy_q) * 32'(outW) + 32'(ox_q)) : ram_wraddr_q;
  end

  // State and output registers; reset clears every output at once so an
  // aborted copy never leaves a write strobe behind.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_LOAD;
      mode_q       <= MODE_COPY;
      ox_q         <= '0;
      oy_q         <= '0;
      tap_q        <= '0;
      acc_q        <= '0;
      rom_addr_q   <= '0;
      ram_wraddr_q <= '0;
      ram_data_q   <= '0;
      ram_wren_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      ox_q         <= ox_d;
      oy_q         <= oy_d;
      tap_q        <= tap_d;
      acc_q        <= acc_d;
      rom_addr_q   <= rom_addr_d;
      ram_wraddr_q <= ram_wraddr_d;
      ram_data_q   <= ram_data_d;
      ram_wren_q   <= (state_d == S_WR);
      done_q       <= (state_d == S_DONE);
    end
  end

  assign rom_addr_o   = rom_addr_q;
  assign ram_wraddr_o = ram_wraddr_q;
  assign ram_data_o   = ram_data_q;
  assign ram_wren_o   = ram_wren_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_scale_copier.sv
// tb_scale_copier
//   Scoreboard bench for scale_copier on a small image. Expected writes are
//   queued when a run is started and popped as the framebuffer strobe appears.
module tb_scale_copier;

  localparam int W     = 16;
  localparam int H     = 12;
  localparam int ROM_N = W * H;
  localparam int RAM_N = 4 * W * H;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  seletor = 2'b10;
  logic [7:0]  romData = 8'h00;
  logic [18:0] romAddr;
  logic [18:0] ramWraddr;
  logic [7:0]  ramData;
  logic        ramWren;
  logic        done;

  typedef struct {
    int         addr;
    logic [7:0] data;
  } exp_t;

  exp_t       sbQ[$];
  logic [7:0] rom    [0:ROM_N-1];
  logic [7:0] ramMem [0:RAM_N-1];
  bit         written[0:RAM_N-1];
  int         checks = 0;
  int         errors = 0;
  int         runCycles;
  int         runWrites;
  int         lastAddr;
  bit         runDone;

  always #5 clk = ~clk;

  scale_copier #(.IMG_W(W), .IMG_H(H)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .seletor_i   (seletor),
    .rom_addr_o  (romAddr),
    .rom_data_i  (romData),
    .ram_wraddr_o(ramWraddr),
    .ram_data_o  (ramData),
    .ram_wren_o  (ramWren),
    .done_o      (done)
  );

  // Synchronous ROM with one clock of read latency.
  always @(posedge clk) begin
    romData <= (int'(romAddr) < ROM_N) ? rom[int'(romAddr)] : 8'h00;
  end

  // Builds the expected write list for the given mode from the ROM contents,
  // then releases reset on a falling edge.
  task automatic applyStimulus(input logic [1:0] sel);
    int   outW;
    int   outH;
    int   sum;
    exp_t e;
    sbQ.delete();
    for (int i = 0; i < RAM_N; i++) begin
      written[i] = 1'b0;
      ramMem[i]  = 8'h00;
    end
    runCycles = 0;
    runWrites = 0;
    lastAddr  = -1;
    runDone   = 1'b0;
    seletor   = sel;
    case (sel)
      2'b00:   begin outW = 2 * W; outH = 2 * H; end
      2'b01:   begin outW = W / 2; outH = H / 2; end
      default: begin outW = W;     outH = H;     end
    endcase
    for (int oy = 0; oy < outH; oy++) begin
      for (int ox = 0; ox < outW; ox++) begin
        e.addr = oy * outW + ox;
        case (sel)
          2'b00: e.data = rom[(oy / 2) * W + ox / 2];
          2'b01: begin
            sum = int'(rom[2 * oy * W + 2 * ox]) + int'(rom[2 * oy * W + 2 * ox + 1])
                + int'(rom[(2 * oy + 1) * W + 2 * ox]) + int'(rom[(2 * oy + 1) * W + 2 * ox + 1]);
            e.data = 8'(sum / 4);
          end
          default: e.data = rom[oy * W + ox];
        endcase
        sbQ.push_back(e);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Watches the DUT on falling edges, pops the scoreboard on each write and
  // checks the protocol every cycle. Returns early after stopAfter writes.
  task automatic checkOutput(input int expCycles, input int stopAfter);
    exp_t        e;
    logic [18:0] held;
    int          a;
    while (!runDone && runCycles < expCycles + 20) begin
      @(negedge clk);
      runCycles++;
      checks++;
      if (ramWren === 1'b1 && done === 1'b1) begin
        errors++;
        $display("[TB] FAIL wren_with_done cycle %0d: ram_wren=%b done=%b, required not both high", runCycles, ramWren, done);
      end
      checks++;
      if (int'(romAddr) > ROM_N - 1) begin
        errors++;
        $display("[TB] FAIL rom_addr_range cycle %0d: got %0d, required <= %0d", runCycles, romAddr, ROM_N - 1);
      end
      if (ramWren === 1'b1) begin
        runWrites++;
        a = int'(ramWraddr);
        lastAddr = a;
        checks++;
        if (a >= RAM_N) begin
          errors++;
          $display("[TB] FAIL ram_addr_range write %0d: got %0d, required < %0d", runWrites, a, RAM_N);
        end else begin
          if (written[a]) begin
            errors++;
            $display("[TB] FAIL duplicate_write addr %0d: written twice, required once", a);
          end
          written[a] = 1'b1;
          ramMem[a]  = ramData;
        end
        checks++;
        if (sbQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL extra_write write %0d: got addr %0d, required no write", runWrites, a);
        end else begin
          e = sbQ.pop_front();
          if (ramWraddr !== 19'(e.addr) || ramData !== e.data) begin
            errors++;
            $display("[TB] FAIL write_%0d: got addr %0d data %0d, required addr %0d data %0d",
                     runWrites, ramWraddr, ramData, e.addr, e.data);
          end
        end
        if (runWrites == stopAfter) return;
      end
      if (done === 1'b1) runDone = 1'b1;
    end
    checks++;
    if (!runDone) begin
      errors++;
      $display("[TB] FAIL done_timeout: done=%b after %0d cycles, required 1", done, runCycles);
    end
    checks++;
    if (runCycles != expCycles) begin
      errors++;
      $display("[TB] FAIL done_latency: got %0d cycles, required %0d", runCycles, expCycles);
    end
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL missing_writes: %0d expected writes left, required 0", sbQ.size());
    end
    held = romAddr;
    repeat (4) @(negedge clk);
    checks++;
    if (done !== 1'b1 || ramWren !== 1'b0 || romAddr !== held) begin
      errors++;
      $display("[TB] FAIL done_hold: done=%b wren=%b rom_addr=%0d, required 1 0 %0d", done, ramWren, romAddr, held);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    checks++;
    if (romAddr !== 19'd0 || ramWraddr !== 19'd0 || ramData !== 8'd0 || ramWren !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: rom_addr=%0d wraddr=%0d data=%0d wren=%b done=%b, required all 0",
               romAddr, ramWraddr, ramData, ramWren, done);
    end
  endtask

  task automatic test_copy();
    for (int i = 0; i < ROM_N; i++) rom[i] = 8'(i);
    applyStimulus(2'b10);
    checkOutput(1 + 3 * ROM_N, -1);
    checks++;
    if (runWrites != ROM_N || lastAddr != ROM_N - 1) begin
      errors++;
      $display("[TB] FAIL copy_count: got %0d writes last %0d, required %0d last %0d", runWrites, lastAddr, ROM_N, ROM_N - 1);
    end
    checks++;
    if (ramMem[37] !== 8'd37) begin
      errors++;
      $display("[TB] FAIL copy_pixel37: got %0d, required 37", ramMem[37]);
    end
    reset = 1'b1;
  endtask

  task automatic test_zoom();
    logic [7:0] r0;
    logic [7:0] r1;
    for (int i = 0; i < ROM_N; i++) rom[i] = 8'($urandom_range(0, 255));
    rom[1] = ~rom[0];
    r0 = rom[0];
    r1 = rom[1];
    applyStimulus(2'b00);
    checkOutput(1 + 12 * ROM_N, -1);
    checks++;
    if (ramMem[0] !== r0 || ramMem[1] !== r0 || ramMem[2 * W] !== r0 || ramMem[2 * W + 1] !== r0) begin
      errors++;
      $display("[TB] FAIL zoom_block: got %0d %0d %0d %0d, required all %0d",
               ramMem[0], ramMem[1], ramMem[2 * W], ramMem[2 * W + 1], r0);
    end
    checks++;
    if (ramMem[2] !== r1) begin
      errors++;
      $display("[TB] FAIL zoom_next: got %0d, required %0d", ramMem[2], r1);
    end
    checks++;
    if (runWrites != 4 * ROM_N || lastAddr != 4 * ROM_N - 1) begin
      errors++;
      $display("[TB] FAIL zoom_count: got %0d writes last %0d, required %0d last %0d", runWrites, lastAddr, 4 * ROM_N, 4 * ROM_N - 1);
    end
    reset = 1'b1;
  endtask

  task automatic test_half();
    for (int i = 0; i < ROM_N; i++) rom[i] = 8'($urandom_range(0, 255));
    rom[0]     = 8'd10;
    rom[1]     = 8'd20;
    rom[W]     = 8'd30;
    rom[W + 1] = 8'd41;
    applyStimulus(2'b01);
    checkOutput(1 + 9 * (ROM_N / 4), -1);
    checks++;
    if (ramMem[0] !== 8'd25) begin
      errors++;
      $display("[TB] FAIL half_avg: got %0d, required 25", ramMem[0]);
    end
    checks++;
    if (runWrites != ROM_N / 4) begin
      errors++;
      $display("[TB] FAIL half_count: got %0d writes, required %0d", runWrites, ROM_N / 4);
    end
    reset = 1'b1;
    for (int i = 0; i < ROM_N; i++) rom[i] = 8'd255;
    applyStimulus(2'b01);
    checkOutput(1 + 9 * (ROM_N / 4), -1);
    checks++;
    if (ramMem[0] !== 8'd255 || ramMem[ROM_N / 4 - 1] !== 8'd255) begin
      errors++;
      $display("[TB] FAIL half_saturate: got %0d %0d, required 255 255", ramMem[0], ramMem[ROM_N / 4 - 1]);
    end
    reset = 1'b1;
  endtask

  task automatic test_reset_midcopy();
    for (int i = 0; i < ROM_N; i++) rom[i] = 8'(i * 3);
    applyStimulus(2'b10);
    checkOutput(1 + 3 * ROM_N, 100);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (romAddr !== 19'd0 || ramWraddr !== 19'd0 || ramData !== 8'd0 || ramWren !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midcopy_reset: rom_addr=%0d wraddr=%0d data=%0d wren=%b done=%b, required all 0",
               romAddr, ramWraddr, ramData, ramWren, done);
    end
    applyStimulus(2'b00);
    checkOutput(1 + 12 * ROM_N, -1);
    checks++;
    if (runWrites != 4 * ROM_N || !written[0]) begin
      errors++;
      $display("[TB] FAIL midcopy_restart: got %0d writes addr0 %b, required %0d writes addr0 1", runWrites, written[0], 4 * ROM_N);
    end
    reset = 1'b1;
  endtask

  task automatic test_seletor_toggle();
    for (int i = 0; i < ROM_N; i++) rom[i] = 8'($urandom_range(0, 255));
    applyStimulus(2'b10);
    checkOutput(1 + 3 * ROM_N, 50);
    seletor = 2'b01;
    checkOutput(1 + 3 * ROM_N, -1);
    checks++;
    if (runWrites != ROM_N || lastAddr != ROM_N - 1) begin
      errors++;
      $display("[TB] FAIL toggle_count: got %0d writes last %0d, required %0d last %0d", runWrites, lastAddr, ROM_N, ROM_N - 1);
    end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_copy();
    test_zoom();
    test_half();
    test_reset_midcopy();
    test_seletor_toggle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scale_copier.md
SCALE_COPIER -- requirements
Module: scale_copier

Interface
REQ-001 Parameter IMG_W, default 160, source image width in pixels.
REQ-002 Parameter IMG_H, default 120, source image height in pixels.
REQ-003 clk  input  1  pixel clock (25 MHz VGA clock); all state changes on its rising edge.
REQ-004 reset  input  1  reset, asynchronous and active-high.
REQ-005 seletor  input  2  scale mode: 00 = 2x zoom, 01 = 1/2 shrink, 10/11 = 1x copy.
REQ-006 rom_addr  output  19  source ROM read address, registered.
REQ-007 rom_data  input  8  source ROM pixel; read latency 1 clk (value in cycle k+1 belongs to rom_addr in cycle k).
REQ-008 ram_wraddr  output  19  framebuffer write address, registered.
REQ-009 ram_data  output  8  framebuffer write data, registered.
REQ-010 ram_wren  output  1  framebuffer write strobe; one cycle per output pixel.
REQ-011 done  output  1  high once the whole scaled image has been written.

Function
REQ-012 Output size SHALL be: 2x -> (2*IMG_W)x(2*IMG_H); 1/2 -> (IMG_W/2)x(IMG_H/2); 1x -> IMG_WxIMG_H.
REQ-013 Output pixels SHALL be written in raster order; ram_wraddr = oy*OUT_W + ox, where OUT_W is the output width.
REQ-014 Source address SHALL be sy*IMG_W + sx; 1x: sx=ox, sy=oy; 2x: sx=ox>>1, sy=oy>>1 (nearest neighbour).
REQ-015 In 1/2 mode, the four taps (2ox,2oy), (2ox+1,2oy), (2ox,2oy+1), (2ox+1,2oy+1) SHALL be read in that order.
REQ-016 The 1/2-mode output SHALL be (sum of 4 taps)>>2, using a 10-bit unsigned accumulator with no overflow and truncation toward zero.
REQ-017 FSM states:
- LOAD: latch seletor into mode register; clear counters and accumulator.
- RD: drive rom_addr for the current tap.
- CAP: capture rom_data, accumulate.
- WR: assert ram_wren.
- DONE.
REQ-018 Transitions:
- LOAD->RD.
- RD->CAP.
- CAP->RD if taps remain, else CAP->WR.
- WR->RD if pixels remain, else WR->DONE.
- DONE is held until reset.
REQ-019 Cycles per output pixel SHALL be 3 in 1x and 2x modes, and 9 in 1/2 mode.
REQ-020 Total cycles from LOAD to done for the default parameters SHALL be: 1x 57600+1, 2x 230400+1, 1/2 43200+1; each total is less than one 800x525 frame.
REQ-021 ram_wren SHALL be high only in WR; ram_wraddr and ram_data SHALL be stable while ram_wren is high.
REQ-022 done SHALL rise on the edge after the last WR and stay high; ram_wren SHALL never be high while done is high.
REQ-023 seletor changes after LOAD SHALL be ignored until the next reset; restart on a mode change is the parent's job, via reset.
REQ-024 rom_addr SHALL hold its last value in WR and DONE; addresses SHALL never exceed IMG_W*IMG_H-1 (ROM) or OUT_W*OUT_H-1 (RAM).

Reset
REQ-025 While reset is high, all outputs SHALL be 0 immediately (asynchronously) and the FSM SHALL be in LOAD.
REQ-026 The first edge after reset deassertion SHALL execute LOAD; reset asserted mid-copy SHALL abort without a partial write and restart at ram_wraddr 0.

Verification
REQ-027 1x copy: seletor=10, ROM[a]=a[7:0] -> 19200 writes, RAM[k]=k[7:0], last ram_wraddr 19199, done after 57601 cycles.
REQ-028 2x zoom: seletor=00 -> RAM[0], RAM[1], RAM[320], RAM[321] all = ROM[0]; RAM[2] = ROM[1]; 76800 writes; last ram_wraddr 76799.
REQ-029 1/2 shrink: ROM[0]=10, ROM[1]=20, ROM[160]=30, ROM[161]=41 -> RAM[0]=25; all taps 255 -> 255; 4800 writes.
REQ-030 Reset mid-copy: assert reset during write 5000 with seletor switched 10->00 -> outputs 0 asynchronously; copy restarts in 2x mode from ram_wraddr 0.
REQ-031 seletor toggled 10->01 mid-copy without reset -> 1x behaviour and write count unchanged.
REQ-032 Protocol check on every cycle: ram_wren and done are never high together; each ram_wraddr is written exactly once per run.
